// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/result handshake bundle for the sequential multiplier.
// The master side issues operands and consumes the product; the slave side
// is the multiplier itself.
interface seq_mult_if #(
    parameter int WIDTH = 4
) ();

    // Operand channel
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mode;

    // Result channel
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    // Status
    logic               busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/seq_mult.sv
// seq_mult: radix-2 sequential shift-add multiplier, unsigned or two's-complement.
// Signed operands are reduced to magnitudes on capture, multiplied unsigned over
// exactly WIDTH cycles, and the result sign is applied when the product is loaded.
module seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    seq_mult_if.slave bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q,     state_d;
    logic [PW-1:0]    mcand_q,     mcand_d;     // multiplicand, shifted left each step
    logic [WIDTH-1:0] mplier_q,    mplier_d;    // multiplier, consumed LSB-first
    logic [PW-1:0]    acc_q,       acc_d;       // running partial-product sum
    logic [CW-1:0]    cnt_q,       cnt_d;       // steps already performed
    logic             neg_q,       neg_d;       // result must be negated
    logic [PW-1:0]    product_q,   product_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic [PW-1:0]    acc_step;                 // accumulator after this cycle's step
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Unsigned magnitude of a two's-complement value; the most-negative value
    // maps to 2^(WIDTH-1), which still fits because the result is unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + W_ONE) : x;
    endfunction

    // Operand conditioning and one shift-add step, shared by the next-state logic.
    always_comb begin
        a_mag    = bus.signed_mode ? magnitude(bus.a) : bus.a;
        b_mag    = bus.signed_mode ? magnitude(bus.b) : bus.b;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case below leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    product_d = neg_q ? -acc_step : acc_step;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered, so derive them from the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == CALC);
    end

    // State and datapath registers with asynchronous reset to an idle block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the accumulator and operand registers are ordinary flops, not
            // a memory array, so they are cleared here like the control state.
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed before this edge, independent of statement order.
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.product   = product_q;

endmodule
